// File: rtl/vbuffer_fill_pkg.sv
// vbuffer_fill_pkg: shared FSM encoding and sizing helper for the line-buffer writer.
package vbuffer_fill_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_e;
  function automatic int cnt_width(input int iwidth);
    return iwidth > 1 ? iwidth - 1 : 1;
  endfunction
endpackage

// File: rtl/vbuffer_fill.sv
// vbuffer_fill: ping-pong writer that fetches pixels over req/ack and fills the half-buffer the reader is not in.
//  Clk/ResetN           clock, async active-low reset
//  FrameStart/BaseAddr  restart fetch at BaseAddr (sampled on FrameStart), clear Underrun
//  ReadIndex/Blank      scan-out position and blanking
//  MemReq/MemAddr       read request, address stable while MemReq high
//  MemAck/MemData       one-cycle ack with data
//  Write/WriteIndex/DataOut  buffer write port, one cycle after an accepted ack
//  Underrun             sticky: reader entered the half still being filled
module vbuffer_fill
  import vbuffer_fill_pkg::*;
#(
  parameter int IWIDTH = 2,
  parameter int BPP    = 6,
  parameter int PSIZE  = 4,
  parameter int AWIDTH = 16
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              FrameStart,
  input  logic [AWIDTH-1:0] BaseAddr,
  input  logic [IWIDTH-1:0] ReadIndex,
  input  logic              Blank,
  output logic              MemReq,
  output logic [AWIDTH-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [BPP-1:0]    MemData,
  output logic              Write,
  output logic [IWIDTH-1:0] WriteIndex,
  output logic [BPP-1:0]    DataOut,
  output logic              Underrun
);
  localparam int HS = PSIZE / 2;
  localparam int CW = cnt_width(IWIDTH);
  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic              half_q, half_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              restart_q, restart_d;
  logic              write_q, write_d;
  logic [IWIDTH-1:0] widx_q, widx_d;
  logic [BPP-1:0]    data_q, data_d;
  logic              underrun_q, underrun_d;
  logic              rd_half, take, drop, last;
  logic [AWIDTH-1:0] restart_addr;
  assign rd_half      = ReadIndex[IWIDTH-1];
  assign take         = (state_q == REQ) && mem_req_q && MemAck;
  // A FrameStart arriving with the ack, or an earlier one still pending, discards the pixel.
  assign drop         = restart_q || FrameStart;
  assign last         = cnt_q == CW'(HS - 1);
  assign restart_addr = FrameStart ? BaseAddr : base_q;
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    addr_d     = addr_q;
    base_d     = FrameStart ? BaseAddr : base_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    restart_d  = restart_q;
    write_d    = 1'b0;
    widx_d     = widx_q;
    data_d     = data_q;
    underrun_d = FrameStart ? 1'b0
               : underrun_q | (!Blank && state_q == REQ && rd_half == half_q);
    if (state_q != REQ) begin
      if (FrameStart) begin
        state_d   = REQ;
        mem_req_d = 1'b1;
        addr_d    = BaseAddr;
        half_d    = 1'b0;
        cnt_d     = '0;
        restart_d = 1'b0;
      end else if (state_q == HOLD && rd_half == half_q) begin
        state_d   = REQ;
        mem_req_d = 1'b1;
        half_d    = ~half_q;
      end
    end else if (take) begin
      mem_req_d = 1'b0;
      if (drop) begin
        addr_d     = restart_addr;
        half_d     = 1'b0;
        cnt_d      = '0;
        restart_d  = 1'b0;
        underrun_d = 1'b0;
      end else begin
        write_d = 1'b1;
        widx_d  = (IWIDTH'(half_q) << (IWIDTH - 1)) | IWIDTH'(cnt_q);
        data_d  = MemData;
        addr_d  = addr_q + AWIDTH'(1);
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        state_d = last ? HOLD : REQ;
      end
    end else begin
      // An outstanding request is never withdrawn; a restart waits for its ack.
      mem_req_d = 1'b1;
      restart_d = restart_q | FrameStart;
    end
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      addr_q     <= '0;
      base_q     <= '0;
      half_q     <= 1'b0;
      cnt_q      <= '0;
      restart_q  <= 1'b0;
      write_q    <= 1'b0;
      widx_q     <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      restart_q  <= restart_d;
      write_q    <= write_d;
      widx_q     <= widx_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end
  assign MemReq     = mem_req_q;
  assign MemAddr    = addr_q;
  assign Write      = write_q;
  assign WriteIndex = widx_q;
  assign DataOut    = data_q;
  assign Underrun   = underrun_q;
endmodule

// File: tb/tb_vbuffer_fill.sv
// tb_vbuffer_fill: randomized memory responder with a pixel-stream reference model for vbuffer_fill.
module tb_vbuffer_fill;
  localparam int IW = 2, BPP = 6, PS = 4, AW = 16, HS = PS / 2;
  logic          Clk = 1'b0, ResetN, FrameStart, Blank, MemReq, MemAck, Write, Underrun;
  logic [AW-1:0] BaseAddr, MemAddr;
  logic [IW-1:0] ReadIndex, WriteIndex;
  logic [BPP-1:0] MemData, DataOut;
  always #5 Clk = ~Clk;
  vbuffer_fill #(.IWIDTH(IW), .BPP(BPP), .PSIZE(PS), .AWIDTH(AW)) dut (
    .Clk(Clk), .ResetN(ResetN), .FrameStart(FrameStart), .BaseAddr(BaseAddr),
    .ReadIndex(ReadIndex), .Blank(Blank), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .Write(Write), .WriteIndex(WriteIndex),
    .DataOut(DataOut), .Underrun(Underrun)
  );
  int vectors = 0, errors = 0;
  int seed, ack_delay, wait_cnt, req_cycles;
  int orphan, gap_err, addr_err, gate_err, n_w, filled_half;
  bit fs_next, fs_on_ack, req_prev, awaiting, visited;
  logic [AW-1:0]  addr_prev;
  logic [AW-1:0]  acks[$];
  logic [IW-1:0]  w_idx[$];
  logic [BPP-1:0] w_dat[$];
  function automatic logic [BPP-1:0] pix(input logic [AW-1:0] a);
    return BPP'((32'(a) * 5) ^ (32'(a) >> 7) ^ seed);
  endfunction
  // One clock: observe outputs at the falling edge, then act as memory and drive FrameStart.
  task automatic step();
    bit acked;
    @(negedge Clk);
    acked = MemAck;
    if (awaiting && ReadIndex[IW-1] == filled_half[0]) visited = 1;
    if (MemReq && awaiting) begin
      if (!visited) gate_err++;
      awaiting = 0;
    end
    if (MemReq) req_cycles++;
    if (MemReq && acked) gap_err++;
    if (MemReq && req_prev && !acked && MemAddr !== addr_prev) addr_err++;
    if (Write) begin
      if (!acked) orphan++;
      w_idx.push_back(WriteIndex);
      w_dat.push_back(DataOut);
      n_w++;
      if (n_w % HS == 0) begin
        awaiting = 1;
        visited = 0;
        filled_half = (n_w / HS - 1) % 2;
      end
    end
    req_prev = MemReq;
    addr_prev = MemAddr;
    MemAck = 0;
    FrameStart = 0;
    if (MemReq && ResetN) begin
      if (wait_cnt >= ack_delay) begin
        MemAck = 1;
        MemData = pix(MemAddr);
        acks.push_back(MemAddr);
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
    if (fs_next || (fs_on_ack && MemAck)) begin
      FrameStart = 1;
      fs_next = 0;
      fs_on_ack = 0;
      acks.delete();
      w_idx.delete();
      w_dat.delete();
      n_w = 0;
      awaiting = 0;
    end
  endtask
  task automatic start_frame(input logic [AW-1:0] base);
    BaseAddr = base;
    fs_next = 1;
    step();
  endtask
  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && w_idx.size() < n; i++) step();
  endtask
  task automatic do_reset();
    ResetN = 0;
    FrameStart = 0; MemAck = 0; MemData = '0; BaseAddr = '0; ReadIndex = '0; Blank = 1;
    fs_next = 0; fs_on_ack = 0; wait_cnt = 0; req_prev = 0; awaiting = 0; n_w = 0;
    acks.delete(); w_idx.delete(); w_dat.delete();
    for (int i = 0; i < 3; i++) step();
    ResetN = 1;
  endtask
  task automatic test_reset();
    do_reset();
    if (MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq got %b exp 0", MemReq); end
    vectors++;
    if (MemAddr !== '0) begin errors++; $display("FAIL reset_memaddr got %h exp 0", MemAddr); end
    vectors++;
    if ({Write, WriteIndex, DataOut} !== '0) begin
      errors++; $display("FAIL reset_write got %b/%h/%h exp 0/0/0", Write, WriteIndex, DataOut);
    end
    vectors++;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) step();
    if (req_cycles !== 0) begin errors++; $display("FAIL idle_memreq got %0d req cycles exp 0", req_cycles); end
    vectors++;
    if (w_idx.size() !== 0) begin errors++; $display("FAIL idle_write got %0d writes exp 0", w_idx.size()); end
    vectors++;
    if (Underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun got %b exp 0", Underrun); end
    vectors++;
  endtask
  task automatic test_fill();
    Blank = 1; ReadIndex = 0; ack_delay = 2;
    start_frame(16'h0100);
    wait_writes(4, 200);
    for (int i = 0; i < 20; i++) step();
    if (w_idx.size() !== 4) begin errors++; $display("FAIL fill_count got %0d exp 4", w_idx.size()); end
    vectors++;
    for (int n = 0; n < 4 && n < w_idx.size() && n < acks.size(); n++) begin
      if (acks[n] !== AW'(16'h0100 + n)) begin errors++; $display("FAIL fill_addr%0d got %h exp %h", n, acks[n], 16'h0100 + n); end
      if (w_idx[n] !== IW'(n)) begin errors++; $display("FAIL fill_idx%0d got %0d exp %0d", n, w_idx[n], n); end
      if (w_dat[n] !== pix(AW'(16'h0100 + n))) begin errors++; $display("FAIL fill_data%0d got %h exp %h", n, w_dat[n], pix(AW'(16'h0100 + n))); end
      vectors += 3;
    end
    if (MemReq !== 1'b0) begin errors++; $display("FAIL fill_hold_memreq got %b exp 0", MemReq); end
    vectors++;
  endtask
  task automatic test_hold();
    req_cycles = 0;
    ReadIndex = 1;
    for (int i = 0; i < 15; i++) step();
    if (req_cycles !== 0) begin errors++; $display("FAIL hold_memreq got %0d req cycles exp 0", req_cycles); end
    vectors++;
    ReadIndex = 2;
    wait_writes(6, 200);
    for (int i = 0; i < 15; i++) step();
    if (w_idx.size() !== 6) begin errors++; $display("FAIL hold_count got %0d exp 6", w_idx.size()); end
    else begin
      if (acks[4] !== 16'h0104) begin errors++; $display("FAIL hold_addr got %h exp 0104", acks[4]); end
      if (w_idx[4] !== 2'd0 || w_idx[5] !== 2'd1) begin errors++; $display("FAIL hold_idx got %0d,%0d exp 0,1", w_idx[4], w_idx[5]); end
      if (w_dat[4] !== pix(16'h0104)) begin errors++; $display("FAIL hold_data got %h exp %h", w_dat[4], pix(16'h0104)); end
      vectors += 3;
    end
    vectors++;
    if (gate_err !== 0) begin errors++; $display("FAIL hold_gate got %0d early requests exp 0", gate_err); end
    vectors++;
  endtask
  task automatic test_wrap();
    start_frame(16'hFFFF);
    ReadIndex = 0;
    wait_writes(2, 200);
    if (acks.size() < 2 || w_idx.size() < 2) begin errors++; $display("FAIL wrap_count got %0d acks exp 2", acks.size()); end
    else begin
      if (acks[0] !== 16'hFFFF || acks[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h,%h exp ffff,0000", acks[0], acks[1]); end
      if (w_dat[1] !== pix(16'h0000) || w_idx[1] !== 2'd1) begin errors++; $display("FAIL wrap_write got %h@%0d exp %h@1", w_dat[1], w_idx[1], pix(16'h0000)); end
      vectors++;
    end
    vectors++;
  endtask
  task automatic test_underrun();
    Blank = 0; ReadIndex = 2; ack_delay = 30;
    start_frame(16'h0200);
    for (int i = 0; i < 3; i++) step();
    if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_other_half got %b exp 0", Underrun); end
    vectors++;
    ReadIndex = 0;
    step(); step();
    if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_set got %b exp 1", Underrun); end
    vectors++;
    ReadIndex = 2;
    for (int i = 0; i < 5; i++) step();
    if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b exp 1", Underrun); end
    vectors++;
    start_frame(16'h0300);
    step();
    if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %b exp 0", Underrun); end
    vectors++;
    Blank = 1; ReadIndex = 0;
    for (int i = 0; i < 20; i++) step();
    if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_blank got %b exp 0", Underrun); end
    vectors++;
  endtask
  task automatic test_restart();
    do_reset();
    Blank = 1; ReadIndex = 0; ack_delay = 3; orphan = 0;
    start_frame(16'h1000);
    step();
    if (MemReq !== 1'b1) begin errors++; $display("FAIL rs_pending got %b exp 1", MemReq); end
    vectors++;
    start_frame(16'h2000);
    wait_writes(2, 200);
    if (acks.size() < 2 || w_idx.size() < 1) begin errors++; $display("FAIL rs_count got %0d acks exp >=2", acks.size()); end
    else begin
      if (acks[0] !== 16'h1000 || acks[1] !== 16'h2000) begin errors++; $display("FAIL rs_addr got %h,%h exp 1000,2000", acks[0], acks[1]); end
      if (w_dat[0] !== pix(16'h2000) || w_idx[0] !== 2'd0) begin errors++; $display("FAIL rs_write got %h@%0d exp %h@0", w_dat[0], w_idx[0], pix(16'h2000)); end
      vectors++;
    end
    vectors++;
    BaseAddr = 16'h3000;
    fs_on_ack = 1;
    for (int i = 0; i < 100 && fs_on_ack; i++) step();
    wait_writes(1, 100);
    if (acks.size() < 1 || w_idx.size() < 1) begin errors++; $display("FAIL rs_same_count got %0d writes exp >=1", w_idx.size()); end
    else begin
      if (acks[0] !== 16'h3000) begin errors++; $display("FAIL rs_same_addr got %h exp 3000", acks[0]); end
      if (w_dat[0] !== pix(16'h3000) || w_idx[0] !== 2'd0) begin errors++; $display("FAIL rs_same_write got %h@%0d exp %h@0", w_dat[0], w_idx[0], pix(16'h3000)); end
      vectors++;
    end
    vectors++;
    if (orphan !== 0) begin errors++; $display("FAIL rs_orphan got %0d writes without ack exp 0", orphan); end
    vectors++;
    ack_delay = 20;
    for (int i = 0; i < 100 && !MemReq; i++) step();
    #2 ResetN = 0;
    #1;
    if (MemReq !== 1'b0) begin errors++; $display("FAIL rs_async_reset got %b exp 0", MemReq); end
    vectors++;
    do_reset();
  endtask
  task automatic test_random();
    logic [AW-1:0] base;
    orphan = 0; gap_err = 0; addr_err = 0; gate_err = 0;
    Blank = 1;
    for (int f = 0; f < 6; f++) begin
      base = AW'($urandom);
      ack_delay = $urandom_range(0, 3);
      start_frame(base);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 5) == 0) ReadIndex = IW'($urandom);
        step();
      end
      if (w_idx.size() == 0) begin errors++; $display("FAIL rnd_progress frame %0d got 0 writes exp >0", f); end
      vectors++;
      for (int n = 0; n < w_idx.size(); n++) begin
        if (w_idx[n] !== IW'(n % PS) || w_dat[n] !== pix(AW'(base + n))) begin
          errors++;
          $display("FAIL rnd_pixel frame %0d n %0d got %h@%0d exp %h@%0d", f, n, w_dat[n], w_idx[n], pix(AW'(base + n)), n % PS);
        end
        vectors++;
      end
    end
    if (gate_err !== 0) begin errors++; $display("FAIL rnd_gate got %0d exp 0", gate_err); end
    if (orphan !== 0) begin errors++; $display("FAIL rnd_orphan got %0d exp 0", orphan); end
    if (gap_err !== 0) begin errors++; $display("FAIL rnd_req_gap got %0d exp 0", gap_err); end
    if (addr_err !== 0) begin errors++; $display("FAIL rnd_addr_stable got %0d exp 0", addr_err); end
    vectors += 4;
  endtask
  initial begin
    seed = $urandom;
    orphan = 0; gap_err = 0; addr_err = 0; gate_err = 0; ack_delay = 0; filled_half = 0;
    test_reset();
    test_fill();
    test_hold();
    test_wrap();
    test_underrun();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
